// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes and data-memory port of the dmem arbiter.
interface dmem_arbiter_if #(parameter int DW = 32);
    logic          m0_req, m1_req;
    logic          m0_we, m1_we;
    logic [31:0]   m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m1_lock;
    logic          m0_gnt, m1_gnt, m0_stall;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write, mem_peri;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, m1_lock, mem_rdata,
        output m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               mem_addr, mem_wdata, mem_read, mem_write, mem_peri
    );
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, m1_lock, mem_rdata,
        input  m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               mem_addr, mem_wdata, mem_read, mem_write, mem_peri
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage (m0) and a DMA loader (m1).
// Define DMEM_ARB_RR_EN for round-robin on unlocked contention; otherwise m0 has fixed priority.
module dmem_arbiter #(
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    logic          last_q, last_d, locked_q, locked_d, rd_pend_q, rd_id_q;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          g0, g1, pick1, below;
`ifdef DMEM_ARB_RR_EN
    assign pick1 = ~last_q;
`else
    assign pick1 = 1'b0;
`endif
    always_comb begin
        below    = bcnt_q < 4'(MAX_BURST);
        g1       = bus.m1_req & (~bus.m0_req | (locked_q ? below : pick1));
        g0       = bus.m0_req & ~g1;
        last_d   = g1 ? 1'b1 : g0 ? 1'b0 : last_q;
        locked_d = g1 & bus.m1_lock;
        // burst count only advances while m0 is actually being held off
        bcnt_d   = !locked_d ? 4'd0 : (bus.m0_req && below) ? bcnt_q + 4'd1 : bcnt_q;
    end
    assign bus.m0_gnt    = g0;
    assign bus.m1_gnt    = g1;
    assign bus.m0_stall  = bus.m0_req & ~g0;
    assign bus.mem_addr  = g1 ? bus.m1_addr : bus.m0_addr;
    assign bus.mem_wdata = g1 ? bus.m1_wdata : g0 ? bus.m0_wdata : '0;
    assign bus.mem_read  = (g1 & ~bus.m1_we) | (g0 & ~bus.m0_we);
    assign bus.mem_write = (g1 & bus.m1_we) | (g0 & bus.m0_we);
    assign bus.mem_peri  = bus.mem_addr[31:28] == 4'h4;
    assign bus.m0_rvalid = rd_pend_q & ~rd_id_q;
    assign bus.m1_rvalid = rd_pend_q & rd_id_q;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : rdata0_q;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : rdata1_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q    <= 1'b1;
            locked_q  <= 1'b0;
            bcnt_q    <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            locked_q  <= locked_d;
            bcnt_q    <= bcnt_d;
            rd_pend_q <= bus.mem_read;
            rd_id_q   <= g1;
            rdata0_q  <= bus.m0_rdata;
            rdata1_q  <= bus.m1_rdata;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port (synchronous read, 1-cycle latency, peripheral window at 0x4xxxxxxx) between the CPU pipeline MEM stage (master 0) and a UART/debug loader DMA engine (master 1). It grants at most one access per cycle and drives the memory's address, data, read/write and peripheral-select inputs. It routes registered read data back to the owner of the read and generates a CPU stall when master 0 is held off.

## Interface
- `DW`, 32, data width
- `MAX_BURST`, 4, max consecutive locked grants to master 1 while master 0 waits (1..15)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `m0_req` / `m1_req`  in  1  access request
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read
- `m0_addr` / `m1_addr`  in  32  byte address
- `m0_wdata` / `m1_wdata`  in  DW  write data
- `m1_lock`  in  1  master 1 requests to keep ownership for its next access
- `m0_gnt` / `m1_gnt`  out  1  access accepted this cycle (combinational)
- `m0_stall`  out  1  `m0_req & ~m0_gnt`
- `m0_rvalid` / `m1_rvalid`  out  1  read data valid (registered)
- `m0_rdata` / `m1_rdata`  out  DW  read data, valid with rvalid
- `mem_addr`  out  32  to memory Address
- `mem_wdata`  out  DW  to memory Write_data
- `mem_read` / `mem_write`  out  1  to MemRead / MemWrite
- `mem_peri`  out  1  `mem_addr[31:28] == 4'h4`
- `mem_rdata`  in  DW  memory Read_data (valid 1 cycle after read issue)

## Operation
- Grant decision is combinational each cycle from `m*_req`, the priority pointer `last` (1 bit), lock state `locked` (1 bit) and burst counter `bcnt` (4 bits).
- Only one requesting: it is granted.
- Both requesting, `locked=1` and `bcnt<MAX_BURST`: master 1 granted.
- Both requesting, `locked=1` and `bcnt==MAX_BURST`: master 0 granted (forced yield).
- Both requesting otherwise: policy per Configuration.
- Memory port: the granted master's addr/wdata are muxed out. `mem_read = gnt & ~we`, `mem_write = gnt & we`. With no grant, `mem_read = mem_write = 0`, `mem_addr` = master 0 addr, `mem_wdata` = 0.
- On any grant, `last <= granted id`.
- On a master-1 grant: `locked <= m1_lock`, and `bcnt <= bcnt+1` if master 0 was also requesting (saturates at MAX_BURST).
- `locked` and `bcnt` clear to 0 on any master-0 grant, on a master-1 grant with `m1_lock=0`, or on a cycle where `m1_req=0`.
- Read tracking: register `rd_pend <= mem_read` and `rd_id <= granted id`. Next cycle, `m{rd_id}_rvalid=1` and `m{rd_id}_rdata=mem_rdata`. The other master's rdata holds its last value.
- Writes produce no rvalid. Write to peripheral offset 0x18 is passed through unchanged; the memory ignores it.

## Timing
- Reset (async): `last=1` (so master 0 wins first), `locked=0`, `bcnt=0`, `rd_pend=0`, rvalid=0, rdata=0. Grants are still evaluated combinationally, but an access issued in the reset cycle is discarded by memory.
- Read latency: grant in cycle N, rvalid in cycle N+1. Back-to-back reads from alternating masters are allowed, one per cycle, with no bubbles.
- Write completes in the granted cycle.
- A read in N followed by a write in N+1 to the same address: rvalid in N+1 carries the old data.
- Reset asserted between grant and rvalid: rvalid suppressed, pending read lost.

## Configuration
- `DMEM_ARB_RR_EN` defined: contention with no active lock grants the master not equal to `last` (round-robin).
- `DMEM_ARB_RR_EN` not defined: contention with no active lock always grants master 0 (fixed priority). Lock and burst limit still apply, and `last` is still updated.

## Test plan
- Master 0 only: read 0x00000010 after writing 0xDEADBEEF -> `m0_gnt` same cycle, `m0_rvalid=1` with 0xDEADBEEF next cycle, `m0_stall=0`.
- Both request continuously, no lock, RR: grants alternate 0,1,0,1 from reset. Without the macro: master 0 every cycle, `m0_stall=0`, `m1_gnt=0`.
- Master 1 `m1_lock=1`, master 0 requesting, MAX_BURST=4: master 1 granted 4 cycles, then master 0 granted, `m0_stall=1` during those 4 cycles.
- Alternating reads master 0 @0x4 and master 1 @0x40000014: each rvalid lands on the correct master one cycle later, and the other master's rvalid stays 0.
- Master 1 read to 0x40000000 sets `mem_peri=1`. Master 0 address 0x000007FC sets `mem_peri=0`.
- Assert `reset` in the cycle after a read grant: no rvalid, state returns to reset values, and the first post-reset contention grants master 0.
